// File: rtl/rfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Size codes, the writeback request bundle and a saturating adder.
package rfile_pkg;

  localparam int XLEN  = 64;
  localparam int XWDT  = 6;
  localparam int NPORT = 3;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } wb_size_e;

  typedef struct packed {
    logic [XWDT-1:0] idx;
    logic [XLEN-1:0] data;
    wb_size_e        size;
    logic [3:0]      pos;
  } wb_req_t;

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/rfile_wb_rr_sel.sv
// Combinational round-robin grant selection with same-register conflict
// masking; fills output slots in scan order.
module rfile_wb_rr_sel #(
  parameter int XWDT  = 6,
  parameter int NREQ  = 4,
  parameter int NPORT = 3,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int SW   = $clog2(NPORT + 1)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [XWDT-1:0]  idx [NREQ],
  input  logic [PW-1:0]    rr_ptr,
  input  logic             block,
  output logic [NREQ-1:0]  grant,
  output logic [PW-1:0]    slot_req [NPORT],
  output logic [NPORT-1:0] slot_vld,
  output logic             conflict,
  output logic [PW-1:0]    next_ptr
);
  import rfile_pkg::*;

  logic [SW-1:0] count;
  int            i;
  logic          clash;

  always_comb begin
    grant    = '0;
    slot_vld = '0;
    for (int p = 0; p < NPORT; p++) slot_req[p] = '0;
    count    = '0;
    conflict = 1'b0;
    next_ptr = rr_ptr;
    i        = 0;
    clash    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      i = int'(rr_ptr) + k;
      if (i >= NREQ) i = i - NREQ;
      if (!block && valid[i] && int'(count) < NPORT) begin
        // r0 never conflicts: writes to it are discarded anyway
        clash = 1'b0;
        for (int j = 0; j < NREQ; j++)
          if (grant[j] && idx[j] == idx[i] && idx[i] != '0)
            clash = 1'b1;
        if (clash) begin
          conflict = 1'b1;
        end else begin
          grant[i]        = 1'b1;
          slot_req[count] = PW'(i);
          slot_vld[count] = 1'b1;
          count           = count + SW'(1);
          next_ptr        = (i == NREQ - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/rfile_wb_arb.sv
// Writeback arbiter: up to NPORT register-file writes per cycle, 1-cycle latency.
// Optional perf counters when RFILE_WB_ARB_PERF_EN is defined.
module rfile_wb_arb #(
  parameter int XLEN  = 64,
  parameter int XWDT  = 6,
  parameter int NREQ  = 4,
  parameter int NPORT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [XWDT-1:0]  req_idx  [NREQ],
  input  logic [XLEN-1:0]  req_data [NREQ],
  input  logic [1:0]       req_size [NREQ],
  input  logic [3:0]       req_pos  [NREQ],
  input  logic             hold,
  output logic [XWDT-1:0]  rwrites  [NPORT],
  output logic [XLEN-1:0]  rins     [NPORT],
  output logic [1:0]       rwsizes  [NPORT],
  output logic [3:0]       rwposs   [NPORT],
  output logic             we
`ifdef RFILE_WB_ARB_PERF_EN
  ,
  output logic [31:0]      perf_grants,
  output logic [31:0]      perf_conflicts
`endif
);
  import rfile_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    next_ptr;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    slot_req [NPORT];
  logic [NPORT-1:0] slot_vld;
  logic             conflict;

  logic [XWDT-1:0]  idx_q  [NPORT];
  logic [XLEN-1:0]  data_q [NPORT];
  wb_size_e         size_q [NPORT];
  logic [3:0]       pos_q  [NPORT];
  logic             we_q;

  rfile_wb_rr_sel #(
    .XWDT  (XWDT),
    .NREQ  (NREQ),
    .NPORT (NPORT)
  ) u_sel (
    .valid    (req_valid),
    .idx      (req_idx),
    .rr_ptr   (rr_ptr),
    .block    (hold | rst),
    .grant    (grant),
    .slot_req (slot_req),
    .slot_vld (slot_vld),
    .conflict (conflict),
    .next_ptr (next_ptr)
  );

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rr_ptr <= '0;
      for (int p = 0; p < NPORT; p++) begin
        idx_q[p]  <= '0;
        data_q[p] <= '0;
        size_q[p] <= SZ_BYTE;
        pos_q[p]  <= '0;
      end
    end else begin
      we_q   <= |grant;
      rr_ptr <= next_ptr;
      for (int p = 0; p < NPORT; p++) begin
        if (slot_vld[p]) begin
          idx_q[p]  <= req_idx[slot_req[p]];
          data_q[p] <= (req_idx[slot_req[p]] == '0) ?
                       '0 : req_data[slot_req[p]];
          size_q[p] <= wb_size_e'(req_size[slot_req[p]]);
          pos_q[p]  <= req_pos[slot_req[p]];
        end else begin
          idx_q[p]  <= '0;
          data_q[p] <= '0;
          size_q[p] <= SZ_BYTE;
          pos_q[p]  <= '0;
        end
      end
    end
  end

  // A write accepted just before reset is squashed while rst is high
  always_comb begin
    we = we_q & ~rst;
    for (int p = 0; p < NPORT; p++) begin
      rwrites[p] = rst ? '0 : idx_q[p];
      rins[p]    = rst ? '0 : data_q[p];
      rwsizes[p] = rst ? '0 : size_q[p];
      rwposs[p]  = rst ? '0 : pos_q[p];
    end
  end

`ifdef RFILE_WB_ARB_PERF_EN
  logic [31:0] grants_q;
  logic [31:0] conf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      conf_q   <= '0;
    end else begin
      grants_q <= sat_add32(grants_q, 32'($countones(grant)));
      if (conflict) conf_q <= sat_add32(conf_q, 32'd1);
    end
  end

  assign perf_grants    = grants_q;
  assign perf_conflicts = conf_q;
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_rfile_wb_arb.sv
// Directed bench for rfile_wb_arb with a queue of expected port contents.
// Perf checks are active when RFILE_WB_ARB_PERF_EN is defined.
module tb_rfile_wb_arb;
  import rfile_pkg::*;

  localparam int NR = 4;
  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [5:0]    req_idx  [NR];
  logic [63:0]   req_data [NR];
  logic [1:0]    req_size [NR];
  logic [3:0]    req_pos  [NR];
  logic [5:0]    rwrites  [NP];
  logic [63:0]   rins     [NP];
  logic [1:0]    rwsizes  [NP];
  logic [3:0]    rwposs   [NP];
  logic          we;
`ifdef RFILE_WB_ARB_PERF_EN
  logic [31:0]   perf_grants;
  logic [31:0]   perf_conflicts;
`endif

  rfile_wb_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_data  (req_data),
    .req_size  (req_size),
    .req_pos   (req_pos),
    .hold      (hold),
    .rwrites   (rwrites),
    .rins      (rins),
    .rwsizes   (rwsizes),
    .rwposs    (rwposs),
    .we        (we)
`ifdef RFILE_WB_ARB_PERF_EN
    ,
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    wb_req_t s [NP];
    logic    we;
  } exp_t;

  exp_t sbq [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_req_t mk(input int i);
    wb_req_t r;
    r.idx  = req_idx[i];
    r.data = (req_idx[i] == 6'd0) ? 64'd0 : req_data[i];
    r.size = wb_size_e'(req_size[i]);
    r.pos  = req_pos[i];
    return r;
  endfunction

  task automatic setreq(input int i, input logic v, input logic [5:0] id,
                        input logic [63:0] d, input logic [1:0] sz,
                        input logic [3:0] ps);
    req_valid[i] = v;
    req_idx[i]   = id;
    req_data[i]  = d;
    req_size[i]  = sz;
    req_pos[i]   = ps;
  endtask

  // One cycle: check ready, push expected ports, clock, pop and compare
  task automatic tick(input logic [NR-1:0] rdy, input int o0,
                      input int o1, input int o2);
    exp_t e;
    exp_t g;
    int   o [NP];
    o = '{o0, o1, o2};
    #1;
    chk("ready", 64'(req_ready), 64'(rdy));
    for (int p = 0; p < NP; p++)
      e.s[p] = (o[p] < 0) ? '0 : mk(o[p]);
    e.we = (rdy != '0);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("we", 64'(we), 64'(g.we));
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rwrites%0d", p), 64'(rwrites[p]), 64'(g.s[p].idx));
      chk($sformatf("rins%0d", p), rins[p], g.s[p].data);
      chk($sformatf("rwsizes%0d", p), 64'(rwsizes[p]), 64'(g.s[p].size));
      chk($sformatf("rwposs%0d", p), 64'(rwposs[p]), 64'(g.s[p].pos));
    end
  endtask

  task automatic all_distinct(input logic v);
    for (int i = 0; i < NR; i++)
      setreq(i, v, 6'(i + 1), 64'h1000 + 64'(i), 2'(i), 4'(i + 8));
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick('0, -1, -1, -1);
    rst = 1'b0;
  endtask

  int ptr;
  int last [NR];
  int g [3];
  logic [NR-1:0] m;

  initial begin
    for (int i = 0; i < NR; i++) setreq(i, 1'b0, '0, '0, '0, '0);

    // reset state
    tick('0, -1, -1, -1);
`ifdef RFILE_WB_ARB_PERF_EN
    chk("perf_grants_rst", 64'(perf_grants), 64'd0);
    chk("perf_conf_rst", 64'(perf_conflicts), 64'd0);
`endif
    rst = 1'b0;

    // all valid, distinct idx: 0,1,2 then 3,0,1
    all_distinct(1'b1);
    tick(4'b0111, 0, 1, 2);
    tick(4'b1011, 3, 0, 1);
    do_reset();

    // same idx on req0/req1
    setreq(0, 1'b1, 6'd5, 64'hAAAA, 2'd3, 4'd1);
    setreq(1, 1'b1, 6'd5, 64'hBBBB, 2'd2, 4'd2);
    tick(4'b0001, 0, -1, -1);
    req_valid[0] = 1'b0;
    tick(4'b0010, 1, -1, -1);
`ifdef RFILE_WB_ARB_PERF_EN
    chk("perf_conflicts", 64'(perf_conflicts), 64'd1);
`endif
    req_valid = '0;

    // write to r0: granted, data forced to zero
    setreq(2, 1'b1, 6'd0, 64'hDEAD, 2'd1, 4'd3);
    tick(4'b0100, 2, -1, -1);
    req_valid = '0;

    // hold blocks everything
    all_distinct(1'b1);
    hold = 1'b1;
    tick('0, -1, -1, -1);
    hold = 1'b0;
    req_valid = '0;

    // reset right after req1 is accepted (ptr is 3 here)
    setreq(1, 1'b1, 6'd7, 64'h7777, 2'd2, 4'd5);
    tick(4'b0010, 1, -1, -1);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("we_squash", 64'(we), 64'd0);
    chk("rwrites_squash", 64'(rwrites[0]), 64'd0);
    chk("rins_squash", rins[0], 64'd0);
    tick('0, -1, -1, -1);
    rst = 1'b0;
    tick('0, -1, -1, -1);
    all_distinct(1'b1);
    tick(4'b0111, 0, 1, 2);
    do_reset();

    // continuous traffic
    ptr = 0;
    for (int i = 0; i < NR; i++) last[i] = -1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NR; i++)
        setreq(i, 1'b1, 6'(i + 1), {$urandom, $urandom},
               2'($urandom_range(3)), 4'($urandom_range(15)));
      m = '0;
      for (int k = 0; k < 3; k++) begin
        g[k] = (ptr + k) % NR;
        m[g[k]] = 1'b1;
        chk($sformatf("starve%0d", g[k]), 64'((c - last[g[k]]) <= NR), 64'd1);
        last[g[k]] = c;
      end
      tick(m, g[0], g[1], g[2]);
      ptr = (ptr + 3) % NR;
    end
    req_valid = '0;
`ifdef RFILE_WB_ARB_PERF_EN
    chk("perf_grants", 64'(perf_grants), 64'd120);
`endif
    tick('0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
